mux_func_scanner: RTL and testbench

Controller that programs and sequences an external 8x1 multiplexer (mux8x1: data A[7:0], select s[2:0], enable en, output Y) used as a 4-variable Boolean function generator.
- Holds a per-data-line configuration: each line is tied to 0, 1, A or ~A.
- On command, sweeps all 16 input combinations ABCD and samples the mux output.
- Returns the function's 16-bit truth table (minterm mask) and its minterm count.
- Sits between a host/test controller and the mux instance.

---
 rtl/mux_func_scanner.sv | 119 +++++++++++
 tb/tb_mux_func_scanner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_func_scanner.sv
// Sequencer for an external 8x1 mux used as a 4-input function generator.
// Sweeps ABCD = 0..15 and returns the truth table and minterm count.
module mux_func_scanner #(
  parameter int unsigned SETTLE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_code,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_tbl,
  output logic [4:0]  ones_cnt,
  output logic [7:0]  mux_a,
  output logic [2:0]  mux_s,
  output logic        mux_en,
  input  logic        mux_y
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t      state;
  logic [15:0] cfg;
  logic [3:0]  idx;
  logic [3:0]  wait_cnt;
  logic [15:0] mask;
  logic [4:0]  cnt;
  logic        last;

  assign last = (wait_cnt == SETTLE_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg       <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
      mask      <= '0;
      cnt       <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth_tbl <= '0;
      ones_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_valid) cfg <= cfg_code;
          if (start) begin
            state     <= SCAN;
            idx       <= '0;
            wait_cnt  <= '0;
            mask      <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        SCAN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (last) begin
            wait_cnt  <= '0;
            mask[idx] <= mux_y;
            cnt       <= cnt + {4'b0, mux_y};
            if (idx == 4'd15) begin
              // Publish here so results are valid while done is high.
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              truth_tbl <= mask | {mux_y, 15'b0};
              ones_cnt  <= cnt + {4'b0, mux_y};
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mux_a  = '0;
    mux_s  = '0;
    mux_en = 1'b0;
    if (state == SCAN) begin
      mux_en = 1'b1;
      mux_s  = idx[2:0];
      for (int i = 0; i < 8; i++) begin
        unique case (cfg[2*i +: 2])
          2'b00:   mux_a[i] = 1'b0;
          2'b01:   mux_a[i] = 1'b1;
          2'b10:   mux_a[i] = idx[3];
          default: mux_a[i] = ~idx[3];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_func_scanner.sv
// Bench for mux_func_scanner: two instances (SETTLE 0 and 3) driving
// behavioural muxes, checked against a truth-table reference model.
module tb_mux_func_scanner;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        cfg_valid = 0;
  logic [15:0] cfg_code = '0;
  logic        abort = 0;
  logic        start0 = 0;
  logic        start3 = 0;

  logic        cfg_ready0, busy0, done0, mux_en0, mux_y0;
  logic [15:0] truth0;
  logic [4:0]  ones0;
  logic [7:0]  mux_a0;
  logic [2:0]  mux_s0;

  logic        cfg_ready3, busy3, done3, mux_en3, mux_y3;
  logic [15:0] truth3;
  logic [4:0]  ones3;
  logic [7:0]  mux_a3;
  logic [2:0]  mux_s3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mux_y0 = mux_en0 ? mux_a0[mux_s0] : 1'b0;
  assign mux_y3 = mux_en3 ? mux_a3[mux_s3] : 1'b0;

  mux_func_scanner #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready0),
    .cfg_code(cfg_code), .start(start0), .abort(abort),
    .busy(busy0), .done(done0),
    .truth_tbl(truth0), .ones_cnt(ones0),
    .mux_a(mux_a0), .mux_s(mux_s0), .mux_en(mux_en0),
    .mux_y(mux_y0)
  );

  mux_func_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
    .cfg_code(cfg_code), .start(start3), .abort(1'b0),
    .busy(busy3), .done(done3),
    .truth_tbl(truth3), .ones_cnt(ones3),
    .mux_a(mux_a3), .mux_s(mux_s3), .mux_en(mux_en3),
    .mux_y(mux_y3)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Function value for every ABCD, straight from the line assignments.
  function automatic logic [15:0] ref_tbl(input logic [15:0] code);
    logic [15:0] t;
    int f, a, v;
    t = '0;
    for (int k = 0; k < 16; k++) begin
      f = (int'(code) >> (2 * (k % 8))) % 4;
      a = k / 8;
      case (f)
        0: v = 0;
        1: v = 1;
        2: v = a;
        default: v = 1 - a;
      endcase
      t[k] = (v != 0);
    end
    return t;
  endfunction

  function automatic int ref_ones(input logic [15:0] t);
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(t[k]);
    return n;
  endfunction

  task automatic scan(input bit sel, input logic [15:0] code,
                      input bit same, input bit mid_cfg);
    int n, lat, per, obs_lat;
    logic [15:0] exp;
    exp = ref_tbl(code);
    per = sel ? 4 : 1;
    lat = 16 * per + 1;
    cfg_valid = 1;
    cfg_code  = code;
    if (!same) begin
      tick();
      cfg_valid = 0;
    end
    if (sel) start3 = 1;
    else start0 = 1;
    tick();
    start0 = 0;
    start3 = 0;
    cfg_valid = 0;
    n = 1;
    while (!(sel ? done3 : done0) && n < lat + 20) begin
      check("mux_en", sel ? mux_en3 : mux_en0, 1);
      check("mux_s", sel ? mux_s3 : mux_s0, ((n - 1) / per) % 8);
      if (mid_cfg && n == 5) begin
        cfg_valid = 1;
        cfg_code  = 16'h0000;
        check("cfg_ready_scan", cfg_ready0, 0);
      end
      if (mid_cfg && n == 6) cfg_valid = 0;
      tick();
      n++;
    end
    obs_lat = n;
    check("latency", obs_lat, lat);
    check("truth", sel ? truth3 : truth0, exp);
    check("ones", sel ? ones3 : ones0, ref_ones(exp));
    check("busy_done", sel ? busy3 : busy0, 0);
    tick();
    check("done_pulse", sel ? done3 : done0, 0);
    check("ready_after", sel ? cfg_ready3 : cfg_ready0, 1);
  endtask

  initial begin
    logic [15:0] code;
    int seen;
    tick();
    check("rst_ready", cfg_ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_truth", truth0, 0);
    check("rst_ones", ones0, 0);
    check("rst_mux", {mux_a0, mux_s0, mux_en0}, 0);
    rst_n = 1;
    tick();

    scan(0, 16'h4462, 0, 0);
    check("t1_tbl", truth0, 16'hADA8);
    scan(0, 16'hFFFF, 0, 0);
    check("t2_ff", truth0, 16'h00FF);
    scan(0, 16'h5555, 0, 0);
    check("t2_ones16", ones0, 16);
    scan(0, 16'h0000, 0, 0);
    check("t2_zero", truth0, 0);

    // Same-cycle load+start after cfg=0, with a stray mid-scan load.
    scan(0, 16'h5555, 1, 1);
    check("t3_tbl", truth0, 16'hFFFF);

    scan(0, 16'h4462, 0, 0);
    cfg_valid = 1;
    cfg_code  = 16'h0000;
    start0    = 1;
    tick();
    cfg_valid = 0;
    start0    = 0;
    for (int n = 1; n < 10; n++) tick();
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", busy0, 0);
    check("abort_en", mux_en0, 0);
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      if (done0) seen++;
      tick();
    end
    check("abort_nodone", seen, 0);
    check("abort_tbl", truth0, 16'hADA8);

    scan(1, 16'h4462, 0, 0);
    check("t5_tbl", truth3, 16'hADA8);

    for (int r = 0; r < 10; r++) begin
      code = 16'($urandom);
      scan(r % 3 == 2, code, $urandom_range(0, 1) == 1, 0);
    end

    cfg_valid = 1;
    cfg_code  = 16'h4462;
    start0    = 1;
    tick();
    cfg_valid = 0;
    start0    = 0;
    for (int n = 1; n < 8; n++) tick();
    rst_n = 0;
    #1;
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_done", done0, 0);
    check("rst_mid_ready", cfg_ready0, 1);
    check("rst_mid_tbl", {truth0, 11'b0, ones0}, 0);
    check("rst_mid_mux", {mux_a0, mux_s0, mux_en0}, 0);
    tick();
    tick();
    rst_n = 1;
    tick();
    scan(0, 16'h4462, 0, 0);
    check("t6_tbl", truth0, 16'hADA8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
